// File: rtl/wb_pkg.sv
// wb_pkg: shared encodings for the writeback stage and load extension.
package wb_pkg;
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } wb_src_e;
endpackage

// File: rtl/load_ext.sv
// load_ext: selects and sign/zero-extends the addressed byte or halfword of a loaded word.
module load_ext
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      off,
  input  logic [2:0]      ctrl,
  output logic [XLEN-1:0] res
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b   = word[{off, 3'b000} +: 8];
    h   = off[1] ? word[31:16] : word[15:0];
    res = ctrl == LB  ? {{(XLEN-8){b[7]}}, b} :
          ctrl == LH  ? {{(XLEN-16){h[15]}}, h} :
          ctrl == LBU ? {{(XLEN-8){1'b0}}, b} :
          ctrl == LHU ? {{(XLEN-16){1'b0}}, h} :
                        word;
  end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB register, load extension, writeback mux, stall/flush and instret counter.
module wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_wb,
  input  logic             flush_wb,
  input  logic             valid_me,
  input  logic             RUWr_me,
  input  logic [4:0]       Rd_me,
  input  logic [XLEN-1:0]  ALURes_me,
  input  logic [XLEN-1:0]  DMDataRd_me,
  input  logic [2:0]       DMCtrl_me,
  input  logic [XLEN-1:0]  PCinc_me,
  input  logic [1:0]       RUDataWrSrc_me,
  output logic             valid_wb,
  output logic             RUWr_wb,
  output logic [4:0]       Rd_wb,
  output logic [XLEN-1:0]  DataWr_wb,
  output logic [CNT_W-1:0] instret
);
  logic [XLEN-1:0] ld_data;
  logic [XLEN-1:0] wr_data;
  logic            retire;
  load_ext #(.XLEN(XLEN)) u_load_ext (
    .word (DMDataRd_me),
    .off  (ALURes_me[1:0]),
    .ctrl (DMCtrl_me),
    .res  (ld_data)
  );
  always_comb begin
    wr_data = RUDataWrSrc_me == WB_MEM ? ld_data :
              RUDataWrSrc_me == WB_PC4 ? PCinc_me : ALURes_me;
    retire  = valid_wb & ~stall_wb & ~flush_wb;
  end
  // x0 writes and bubbles are squashed here so the bank never needs to check
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_wb  <= 1'b0;
      RUWr_wb   <= 1'b0;
      Rd_wb     <= '0;
      DataWr_wb <= '0;
    end else if (flush_wb) begin
      valid_wb  <= 1'b0;
      RUWr_wb   <= 1'b0;
    end else if (!stall_wb) begin
      valid_wb  <= valid_me;
      RUWr_wb   <= valid_me & RUWr_me & (Rd_me != 5'd0);
      Rd_wb     <= Rd_me;
      DataWr_wb <= wr_data;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) instret <= '0;
    else if (retire) instret <= instret + 1'b1;
  end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: scoreboard bench for wb_stage; expected WB state is queued at drive time.
module tb_wb_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall_wb, flush_wb, valid_me, RUWr_me;
  logic [4:0]  Rd_me;
  logic [31:0] ALURes_me, DMDataRd_me, PCinc_me;
  logic [2:0]  DMCtrl_me;
  logic [1:0]  RUDataWrSrc_me;
  logic        valid_wb, RUWr_wb;
  logic [4:0]  Rd_wb;
  logic [31:0] DataWr_wb;
  logic [63:0] instret;

  wb_stage dut (
    .clk(clk), .rst(rst), .stall_wb(stall_wb), .flush_wb(flush_wb),
    .valid_me(valid_me), .RUWr_me(RUWr_me), .Rd_me(Rd_me),
    .ALURes_me(ALURes_me), .DMDataRd_me(DMDataRd_me), .DMCtrl_me(DMCtrl_me),
    .PCinc_me(PCinc_me), .RUDataWrSrc_me(RUDataWrSrc_me),
    .valid_wb(valid_wb), .RUWr_wb(RUWr_wb), .Rd_wb(Rd_wb),
    .DataWr_wb(DataWr_wb), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic        w;
    logic        dc;
    logic [4:0]  rd;
    logic [31:0] d;
    logic [63:0] cnt;
  } exp_t;

  exp_t        sb[$];
  exp_t        m;
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] off, input logic [2:0] c);
    logic [31:0] sb_w, sh_w;
    logic [7:0]  by;
    logic [15:0] hw;
    sb_w = w >> (off * 8);
    sh_w = w >> (off[1] ? 16 : 0);
    by = sb_w[7:0];
    hw = sh_w[15:0];
    case (c)
      3'b000:  return $signed({by, 24'h0}) >>> 24;
      3'b001:  return $signed({hw, 16'h0}) >>> 16;
      3'b100:  return {24'h0, by};
      3'b101:  return {16'h0, hw};
      default: return w;
    endcase
  endfunction

  task automatic model_reset();
    m = '0;
    sb.delete();
  endtask

  task automatic drive(input logic v, input logic w, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] dm, input logic [2:0] ctl,
                       input logic [31:0] pc, input logic [1:0] src,
                       input logic st, input logic fl, input logic [31:0] ed);
    exp_t e;
    m.cnt = m.cnt + ((m.v && !st && !fl) ? 64'd1 : 64'd0);
    if (fl) begin
      m.v = 1'b0; m.w = 1'b0; m.dc = 1'b1;
    end else if (!st) begin
      m.v = v; m.w = v & w & (rd != 5'd0); m.rd = rd; m.d = ed; m.dc = 1'b0;
    end
    sb.push_back(m);
    valid_me = v; RUWr_me = w; Rd_me = rd; ALURes_me = alu; DMDataRd_me = dm;
    DMCtrl_me = ctl; PCinc_me = pc; RUDataWrSrc_me = src; stall_wb = st; flush_wb = fl;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk("valid_wb", {63'd0, valid_wb}, {63'd0, e.v});
      chk("RUWr_wb", {63'd0, RUWr_wb}, {63'd0, e.w});
      chk("instret", instret, e.cnt);
      if (!e.dc) begin
        chk("Rd_wb", {59'd0, Rd_wb}, {59'd0, e.rd});
        chk("DataWr_wb", {32'd0, DataWr_wb}, {32'd0, e.d});
      end
    end
  endtask

  task automatic bubble();
    drive(0, 0, 0, 0, 0, 3'b010, 0, 2'b00, 0, 0, 32'h0);
  endtask

  localparam logic [31:0] W = 32'h80FF_7F01;

  initial begin
    rst = 1'b1;
    stall_wb = 0; flush_wb = 0; valid_me = 0; RUWr_me = 0; Rd_me = 0;
    ALURes_me = 0; DMDataRd_me = 0; DMCtrl_me = 0; PCinc_me = 0; RUDataWrSrc_me = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {63'd0, valid_wb}, 64'd0);
    chk("rst_ruwr", {63'd0, RUWr_wb}, 64'd0);
    chk("rst_instret", instret, 64'd0);
    rst = 1'b0;

    drive(1, 1, 5, 32'h0000_1234, 0, 3'b010, 0, 2'b00, 0, 0, 32'h0000_1234);
    bubble();

    drive(1, 1, 6,  32'h0000_0003, W, 3'b000, 0, 2'b01, 0, 0, 32'hFFFF_FF80);
    drive(1, 1, 7,  32'h0000_0002, W, 3'b100, 0, 2'b01, 0, 0, 32'h0000_00FF);
    drive(1, 1, 8,  32'h0000_0002, W, 3'b001, 0, 2'b01, 0, 0, 32'hFFFF_80FF);
    drive(1, 1, 9,  32'h0000_0003, W, 3'b001, 0, 2'b01, 0, 0, 32'hFFFF_80FF);
    drive(1, 1, 10, 32'h0000_0000, W, 3'b101, 0, 2'b01, 0, 0, 32'h0000_7F01);
    drive(1, 1, 11, 32'h0000_0001, W, 3'b111, 0, 2'b01, 0, 0, 32'h80FF_7F01);
    drive(1, 1, 12, 32'h0000_0001, W, 3'b000, 0, 2'b01, 0, 0, 32'h0000_007F);

    drive(1, 1, 0, 32'hDEAD_BEEF, 0, 3'b010, 0, 2'b00, 0, 0, 32'hDEAD_BEEF);
    drive(0, 1, 3, 32'h1111_1111, 0, 3'b010, 0, 2'b00, 0, 0, 32'h1111_1111);
    bubble();

    drive(1, 1, 13, 32'hAAAA_0001, 0, 3'b010, 0, 2'b11, 0, 0, 32'hAAAA_0001);
    for (int i = 0; i < 3; i++)
      drive(1, 1, 14, 32'h5555_0000 + i, 0, 3'b010, 0, 2'b00, 1, 0, 32'h0);
    drive(1, 1, 15, 32'h0000_0F0F, 0, 3'b010, 0, 2'b00, 0, 0, 32'h0000_0F0F);

    drive(1, 1, 16, 32'h0000_0042, 0, 3'b010, 0, 2'b00, 1, 1, 32'h0);
    drive(1, 1, 17, 32'h0000_0043, 0, 3'b010, 0, 2'b00, 0, 1, 32'h0);

    drive(1, 1, 1, 32'h0000_0100, 0, 3'b010, 32'h0000_0204, 2'b10, 0, 0, 32'h0000_0204);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, d, p, ed;
      logic [2:0]  c;
      logic [1:0]  s;
      logic [4:0]  r;
      a = $urandom; d = $urandom; p = $urandom; c = 3'($urandom_range(0, 7));
      s = 2'($urandom_range(0, 3)); r = 5'($urandom_range(0, 31));
      ed = s == 2'b01 ? ref_load(d, a[1:0], c) : s == 2'b10 ? p : a;
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r, a, d, c, p, s,
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 6) == 0), ed);
    end

    drive(1, 1, 20, 32'h0000_7777, 0, 3'b010, 0, 2'b00, 0, 0, 32'h0000_7777);
    #3 rst = 1'b1;
    #1;
    chk("async_valid", {63'd0, valid_wb}, 64'd0);
    chk("async_ruwr", {63'd0, RUWr_wb}, 64'd0);
    chk("async_rd", {59'd0, Rd_wb}, 64'd0);
    chk("async_data", {32'd0, DataWr_wb}, 64'd0);
    chk("async_instret", instret, 64'd0);
    #1 rst = 1'b0;
    model_reset();
    drive(1, 1, 21, 32'h0000_0021, 0, 3'b010, 0, 2'b00, 0, 0, 32'h0000_0021);
    bubble();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
